// File: rtl/kl_sram_slave.sv
// kl_sram_slave
//   KLink slave that terminates the bridge request stream on one synchronous
//   single-port SRAM (64-bit words, byte write mask, 1-cycle read latency).
//   Handles single accesses and incrementing bursts of 2^(size-3) beats.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   kl_req_*        request beat in (addr, wen, wdata, wmask, size, srcid)
//   kl_req_valid    request beat valid; kl_req_ready is the accept back
//   kl_resp_*       response beat out (rdata, ren, size, dstid)
//   kl_resp_valid   response beat valid; kl_resp_ready is the accept in
//   sram_*          SRAM port (addr, ce, we, wmask, wdata out; rdata in)
//
// Optional feature
//   KL_SRAM_BOUNDS_CHK_EN: addresses with any bit set above the SRAM range are
//   out of range. Writes are dropped and acked; reads return 64'hDEADBEEF_DEADBEEF.
//   Without the macro the upper address bits are ignored and addresses alias.

module kl_sram_slave #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MAX_SIZE   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           kl_req_addr,
    input  logic                  kl_req_wen,
    input  logic [63:0]           kl_req_wdata,
    input  logic [7:0]            kl_req_wmask,
    input  logic [2:0]            kl_req_size,
    input  logic [4:0]            kl_req_srcid,
    input  logic                  kl_req_valid,
    output logic                  kl_req_ready,
    output logic [63:0]           kl_resp_rdata,
    output logic                  kl_resp_ren,
    output logic [2:0]            kl_resp_size,
    output logic [4:0]            kl_resp_dstid,
    output logic                  kl_resp_valid,
    input  logic                  kl_resp_ready,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [7:0]            sram_wmask,
    output logic [63:0]           sram_wdata,
    input  logic [63:0]           sram_rdata
);

    typedef enum logic [1:0] {StIdle, StWrite, StWack, StRead} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             size_q, size_d;        // raw request size, echoed back
    logic [4:0]             srcid_q, srcid_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;        // next word to access
    logic [4:0]             beats_left_q, beats_left_d; // writes to accept / reads to issue
    logic [4:0]             resp_left_q, resp_left_d;   // read beats still to deliver
    logic                   oob_q, oob_d;

    // Read buffer: two entries, filled one cycle after each issued read.
    logic [63:0]            buf_q [2];
    logic                   rd_ptr_q, wr_ptr_q;
    logic [1:0]             occ_q;
    logic                   pend_q;                // a read was issued last cycle
    logic                   issue;
    logic                   push, pop;
    logic [63:0]            push_data;
    logic [1:0]             used;

    // Request header decode
    logic [2:0]             eff_size;
    logic [4:0]             req_beats;
    logic [ADDR_WIDTH-1:0]  req_base;
    logic                   req_oob;
    logic                   req_fire, resp_fire;
    logic                   unused_addr;

    assign unused_addr = ^{kl_req_addr[2:0], kl_req_addr[31:ADDR_WIDTH+3]};

    always_comb begin
        eff_size = kl_req_size;
        if (kl_req_size < 3'd3 || 32'(kl_req_size) > MAX_SIZE) begin
            eff_size = 3'd3;
        end
        req_beats = 5'd1 << (eff_size - 3'd3);
        // Burst base is aligned to the burst length.
        req_base  = kl_req_addr[ADDR_WIDTH+2:3] & ~ADDR_WIDTH'(req_beats - 5'd1);
`ifdef KL_SRAM_BOUNDS_CHK_EN
        req_oob   = |kl_req_addr[31:ADDR_WIDTH+3];
`else
        req_oob   = 1'b0;
`endif
    end

`ifdef KL_SRAM_BOUNDS_CHK_EN
    assign push_data = oob_q ? 64'hDEAD_BEEF_DEAD_BEEF : sram_rdata;
`else
    assign push_data = sram_rdata;
`endif

    // Ready is held low while reset is asserted so no beat is taken or written.
    assign kl_req_ready = ~rst & ((state_q == StIdle) | (state_q == StWrite));
    assign req_fire     = kl_req_valid & kl_req_ready;

    // Response outputs are driven straight from state and the buffer head, so
    // they stay stable until accepted.
    always_comb begin
        kl_resp_valid = 1'b0;
        kl_resp_ren   = 1'b0;
        kl_resp_rdata = '0;
        kl_resp_size  = '0;
        kl_resp_dstid = '0;
        if (state_q == StWack) begin
            kl_resp_valid = 1'b1;
            kl_resp_size  = size_q;
            kl_resp_dstid = srcid_q;
        end else if (state_q == StRead && occ_q != 2'd0) begin
            kl_resp_valid = 1'b1;
            kl_resp_ren   = 1'b1;
            kl_resp_rdata = buf_q[rd_ptr_q];
            kl_resp_size  = size_q;
            kl_resp_dstid = srcid_q;
        end
    end

    assign resp_fire = kl_resp_valid & kl_resp_ready;
    assign pop       = resp_fire & (state_q == StRead);
    assign push      = pend_q;
    assign used      = occ_q + {1'b0, pend_q};

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        srcid_d      = srcid_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        resp_left_d  = resp_left_q;
        oob_d        = oob_q;
        issue        = 1'b0;
        sram_ce      = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = '0;
        sram_wmask   = '0;
        sram_wdata   = '0;

        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    size_d  = kl_req_size;
                    srcid_d = kl_req_srcid;
                    oob_d   = req_oob;
                    if (kl_req_wen) begin
                        if (!req_oob) begin
                            sram_ce    = 1'b1;
                            sram_we    = 1'b1;
                            sram_addr  = req_base;
                            sram_wmask = kl_req_wmask;
                            sram_wdata = kl_req_wdata;
                        end
                        addr_d       = req_base + ADDR_WIDTH'(1);
                        beats_left_d = req_beats - 5'd1;
                        state_d      = (req_beats != 5'd1) ? StWrite : StWack;
                    end else begin
                        addr_d       = req_base;
                        beats_left_d = req_beats;
                        resp_left_d  = req_beats;
                        state_d      = StRead;
                    end
                end
            end

            StWrite: begin
                if (req_fire) begin
                    if (!oob_q) begin
                        sram_ce    = 1'b1;
                        sram_we    = 1'b1;
                        sram_addr  = addr_q;
                        sram_wmask = kl_req_wmask;
                        sram_wdata = kl_req_wdata;
                    end
                    addr_d       = addr_q + ADDR_WIDTH'(1);
                    beats_left_d = beats_left_q - 5'd1;
                    if (beats_left_q == 5'd1) begin
                        state_d = StWack;
                    end
                end
            end

            StWack: begin
                if (resp_fire) begin
                    state_d = StIdle;
                end
            end

            StRead: begin
                // Issue only if the result is guaranteed a buffer slot; a pop in
                // this cycle frees one, which sustains one beat per cycle.
                issue = (beats_left_q != 5'd0) &&
                        ((used < 2'd2) || (used == 2'd2 && pop));
                if (issue) begin
                    sram_ce      = ~oob_q;
                    sram_addr    = addr_q;
                    addr_d       = addr_q + ADDR_WIDTH'(1);
                    beats_left_d = beats_left_q - 5'd1;
                end
                if (pop) begin
                    resp_left_d = resp_left_q - 5'd1;
                    if (resp_left_q == 5'd1) begin
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            size_q       <= '0;
            srcid_q      <= '0;
            addr_q       <= '0;
            beats_left_q <= '0;
            resp_left_q  <= '0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            srcid_q      <= srcid_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            resp_left_q  <= resp_left_d;
            oob_q        <= oob_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            pend_q <= issue;
            if (push) begin
                buf_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_kl_sram_slave.sv
// tb_kl_sram_slave
//   Self-checking bench for kl_sram_slave: behavioural SRAM behind the DUT,
//   word-array reference model of memory contents, directed cases followed by
//   randomized transactions with random response back-pressure.
//   Honours KL_SRAM_BOUNDS_CHK_EN when defined for both DUT and model.

module tb_kl_sram_slave;

    localparam int unsigned AW    = 12;
    localparam int unsigned MS    = 6;
    localparam int unsigned WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   kl_req_addr  = '0;
    logic          kl_req_wen   = 1'b0;
    logic [63:0]   kl_req_wdata = '0;
    logic [7:0]    kl_req_wmask = '0;
    logic [2:0]    kl_req_size  = '0;
    logic [4:0]    kl_req_srcid = '0;
    logic          kl_req_valid = 1'b0;
    logic          kl_req_ready;
    logic [63:0]   kl_resp_rdata;
    logic          kl_resp_ren;
    logic [2:0]    kl_resp_size;
    logic [4:0]    kl_resp_dstid;
    logic          kl_resp_valid;
    logic          kl_resp_ready = 1'b0;
    logic [AW-1:0] sram_addr;
    logic          sram_ce;
    logic          sram_we;
    logic [7:0]    sram_wmask;
    logic [63:0]   sram_wdata;
    logic [63:0]   sram_rdata = '0;

    kl_sram_slave #(
        .ADDR_WIDTH(AW),
        .MAX_SIZE  (MS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .kl_req_addr  (kl_req_addr),
        .kl_req_wen   (kl_req_wen),
        .kl_req_wdata (kl_req_wdata),
        .kl_req_wmask (kl_req_wmask),
        .kl_req_size  (kl_req_size),
        .kl_req_srcid (kl_req_srcid),
        .kl_req_valid (kl_req_valid),
        .kl_req_ready (kl_req_ready),
        .kl_resp_rdata(kl_resp_rdata),
        .kl_resp_ren  (kl_resp_ren),
        .kl_resp_size (kl_resp_size),
        .kl_resp_dstid(kl_resp_dstid),
        .kl_resp_valid(kl_resp_valid),
        .kl_resp_ready(kl_resp_ready),
        .sram_addr    (sram_addr),
        .sram_ce      (sram_ce),
        .sram_we      (sram_we),
        .sram_wmask   (sram_wmask),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    logic [63:0] mem     [WORDS];   // SRAM contents behind the DUT
    logic [63:0] ref_mem [WORDS];   // expected contents
    logic [63:0] exp_q   [$];
    int          n_vec  = 0;
    int          n_err  = 0;
    int          ce_cnt = 0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM request sampled mid-cycle, applied on the following edge.
    logic          s_ce = 1'b0;
    logic          s_we = 1'b0;
    logic [AW-1:0] s_addr;
    logic [7:0]    s_mask;
    logic [63:0]   s_wdata;

    always @(negedge clk) begin
        s_ce    = sram_ce;
        s_we    = sram_we;
        s_addr  = sram_addr;
        s_mask  = sram_wmask;
        s_wdata = sram_wdata;
        if (sram_ce) ce_cnt++;
    end

    always @(posedge clk) begin
        if (s_ce) begin
            if (s_we) mem[s_addr] <= merge(mem[s_addr], s_wdata, s_mask);
            else      sram_rdata  <= mem[s_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference rules
    function automatic int eff_size(input logic [2:0] s);
        if (s < 3'd3 || 32'(s) > MS) return 3;
        return int'(s);
    endfunction

    function automatic int n_beats(input logic [2:0] s);
        return 1 << (eff_size(s) - 3);
    endfunction

    function automatic int base_word(input logic [31:0] a, input logic [2:0] s);
        int w;
        w = int'((a >> 3) % WORDS);
        return w - (w % n_beats(s));
    endfunction

    function automatic bit is_oob(input logic [31:0] a);
        bit hi;
        hi = (a >> (AW + 3)) != 0;
`ifdef KL_SRAM_BOUNDS_CHK_EN
        return hi;
`else
        return hi & 1'b0;
`endif
    endfunction

    task automatic send_beat(input logic [31:0] a, input logic wen, input logic [63:0] d,
                             input logic [7:0] m, input logic [2:0] s, input logic [4:0] id);
        bit acc;
        acc          = 1'b0;
        kl_req_addr  = a;
        kl_req_wen   = wen;
        kl_req_wdata = d;
        kl_req_wmask = m;
        kl_req_size  = s;
        kl_req_srcid = id;
        kl_req_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = kl_req_ready;
            @(posedge clk);
            #1;
        end
        kl_req_valid = 1'b0;
        if (!acc) check_eq("req_accept_timeout", 64'(acc), 64'd1);
    endtask

    // Collect nb response beats against exp_q; stall 0 = ready high,
    // 1 = ready pattern 1,0,0,1, 2 = random ready.
    task automatic collect(input int nb, input logic ren, input logic [2:0] s,
                           input logic [4:0] id, input int stall,
                           output int first_c, output int last_c, output int max_out);
        int          got;
        int          iss;
        bit          held;
        logic [63:0] held_data;
        logic [63:0] e;
        got     = 0;
        iss     = 0;
        held    = 1'b0;
        first_c = -1;
        last_c  = -1;
        max_out = 0;
        for (int c = 0; c < 400 && got < nb; c++) begin
            case (stall)
                0:       kl_resp_ready = 1'b1;
                1:       kl_resp_ready = (c % 4 == 0) || (c % 4 == 3);
                default: kl_resp_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (held) begin
                check_eq("resp_hold_valid", 64'(kl_resp_valid), 64'd1);
                check_eq("resp_hold_data", kl_resp_rdata, held_data);
            end
            held      = kl_resp_valid && !kl_resp_ready;
            held_data = kl_resp_rdata;
            if (sram_ce && !sram_we) iss++;
            if (kl_resp_valid && kl_resp_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hX;
                check_eq("resp_data", kl_resp_rdata, e);
                check_eq("resp_ren", 64'(kl_resp_ren), 64'(ren));
                check_eq("resp_size", 64'(kl_resp_size), 64'(s));
                check_eq("resp_dstid", 64'(kl_resp_dstid), 64'(id));
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            if (iss - got > max_out) max_out = iss - got;
            @(posedge clk);
            #1;
        end
        kl_resp_ready = 1'b0;
        check_eq("resp_count", 64'(got), 64'(nb));
        check_eq("resp_idle_after", 64'(kl_resp_valid), 64'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [2:0] s, input logic [4:0] id,
                            input logic [63:0] d0, input logic [7:0] m0, input int stall);
        int          nb;
        int          base;
        bit          oob;
        int          ce0;
        int          f;
        int          l;
        int          mo;
        logic [63:0] d;
        logic [7:0]  m;
        nb   = n_beats(s);
        base = base_word(a, s);
        oob  = is_oob(a);
        ce0  = ce_cnt;
        for (int n = 0; n < nb; n++) begin
            d = (n == 0) ? d0 : {$urandom, $urandom};
            m = (n == 0) ? m0 : 8'($urandom);
            if (n == 0) begin
                send_beat(a, 1'b1, d, m, s, id);
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                // Follow-on header fields must be ignored.
                send_beat($urandom, 1'b1, d, m, 3'($urandom), 5'($urandom));
            end
            if (!oob) ref_mem[base + n] = merge(ref_mem[base + n], d, m);
        end
        exp_q.push_back(64'd0);
        collect(1, 1'b0, s, id, stall, f, l, mo);
        check_eq("wr_ce_count", 64'(ce_cnt - ce0), oob ? 64'd0 : 64'(nb));
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] s, input logic [4:0] id,
                           input int stall);
        int nb;
        int base;
        bit oob;
        int ce0;
        int f;
        int l;
        int mo;
        nb   = n_beats(s);
        base = base_word(a, s);
        oob  = is_oob(a);
        for (int n = 0; n < nb; n++) begin
            exp_q.push_back(oob ? 64'hDEAD_BEEF_DEAD_BEEF : ref_mem[base + n]);
        end
        ce0 = ce_cnt;
        send_beat(a, 1'b0, {$urandom, $urandom}, 8'($urandom), s, id);
        collect(nb, 1'b1, s, id, stall, f, l, mo);
        check_eq("rd_ce_count", 64'(ce_cnt - ce0), oob ? 64'd0 : 64'(nb));
        check_eq("rd_outstanding_le2", 64'(mo <= 2), 64'd1);
        if (stall == 0) begin
            check_eq("rd_first_latency", 64'(f), 64'd2);
            check_eq("rd_back_to_back", 64'(l - f), 64'(nb - 1));
        end
    endtask

    initial begin
        logic [31:0] a;
        int          got;

        for (int i = 0; i < int'(WORDS); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset: a pending write request must be neither accepted nor issued.
        kl_req_valid = 1'b1;
        kl_req_wen   = 1'b1;
        kl_req_wmask = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 64'(kl_req_ready), 64'd0);
        check_eq("rst_resp_valid", 64'(kl_resp_valid), 64'd0);
        check_eq("rst_sram_ce", 64'(sram_ce), 64'd0);
        check_eq("rst_resp_rdata", kl_resp_rdata, 64'd0);
        kl_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_req_ready", 64'(kl_req_ready), 64'd1);

        // Partial single write, then read back with a different requester.
        do_write(32'h10, 3'd3, 5'd3, 64'h1122_3344_5566_7788, 8'h0F, 0);
        do_read(32'h10, 3'd3, 5'd7, 0);

        // Eight-beat burst at 0x40: fill, then read streaming and under stalls.
        do_write(32'h40, 3'd6, 5'd1, {$urandom, $urandom}, 8'hFF, 0);
        do_read(32'h40, 3'd6, 5'd2, 0);
        do_read(32'h40, 3'd6, 5'd4, 1);

        // Unaligned size-5 write lands on words 4..7.
        do_write(32'h23, 3'd5, 5'd5, {$urandom, $urandom}, 8'hFF, 2);
        do_read(32'h20, 3'd5, 5'd6, 0);

        // Reset during the third beat of a read burst.
        send_beat(32'h80, 1'b0, '0, '0, 3'd6, 5'd9);
        kl_resp_ready = 1'b1;
        got           = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            if (kl_resp_valid && kl_resp_ready) got++;
            @(posedge clk);
            #1;
        end
        check_eq("rst_mid_third_valid", 64'(kl_resp_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_valid", 64'(kl_resp_valid), 64'd0);
        check_eq("rst_mid_rdata", kl_resp_rdata, 64'd0);
        check_eq("rst_mid_dstid", 64'(kl_resp_dstid), 64'd0);
        check_eq("rst_mid_req_ready", 64'(kl_req_ready), 64'd0);
        check_eq("rst_mid_sram_ce", 64'(sram_ce), 64'd0);
        kl_resp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_read(32'h80, 3'd6, 5'd10, 2);

        // Above the SRAM range: bounds-checked builds return the pattern,
        // otherwise the address aliases onto word 0.
        do_write(32'h0000_8008, 3'd3, 5'd11, {$urandom, $urandom}, 8'hF0, 0);
        do_read(32'h0000_8000, 3'd3, 5'd12, 0);
        do_read(32'h0000_8000, 3'd4, 5'd13, 2);

        // Randomized traffic over a small address window.
        for (int t = 0; t < 60; t++) begin
            a       = $urandom;
            a[14:9] = '0;
            if ($urandom_range(0, 3) != 0) a[31:15] = '0;
            if ($urandom_range(0, 1) != 0) begin
                do_write(a, 3'($urandom), 5'($urandom), {$urandom, $urandom}, 8'($urandom),
                         $urandom_range(0, 2));
            end else begin
                do_read(a, 3'($urandom), 5'($urandom), $urandom_range(0, 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
